// File: rtl/tlul_pkg.sv
// TL-UL channel types, opcodes and shared constants.
// Provides tl_h2d_t / tl_d2h_t bundles, opcode enums, d_user default and error data.
package tlul_pkg;

    import top_pkg::*;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    localparam tl_d_user_t TL_D_USER_DEFAULT = '{
        rsp_intg:  7'h0,
        data_intg: 7'h0
    };

    localparam logic [TL_DW-1:0] DataWhenError = {TL_DW{1'b1}};

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/top_pkg.sv
// Top-level TL-UL bus geometry shared by every TL-UL package and block.
// Widths: address, data, source id, sink id, byte lanes and size field.
package top_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

endpackage

// File: rtl/tlul_req_chk.sv
// Combinational legality check of a TL-UL A-channel request.
// Ports: op_i, addr_lsb_i, size_i, mask_i in; err_o high when the request is illegal.
module tlul_req_chk
    import top_pkg::*;
    import tlul_pkg::*;
(
    input  tl_a_op_e          op_i,
    input  logic [1:0]        addr_lsb_i,
    input  logic [TL_SZW-1:0] size_i,
    input  logic [TL_DBW-1:0] mask_i,
    output logic              err_o
);

    logic is_full;
    logic is_wr;
    logic op_ok;

    always_comb begin
        is_full = (op_i == PutFullData);
        is_wr   = is_full || (op_i == PutPartialData);
        op_ok   = is_wr || (op_i == Get);
        err_o   = !op_ok
               || (addr_lsb_i != 2'b00)
               || (size_i > TL_SZW'(2))
               || (is_full && (mask_i != '1))
               || (is_wr && (mask_i == '0));
    end

endmodule

// File: rtl/tlul_reg_adapter.sv
// TL-UL device to simple register-port adapter with one outstanding response.
// Ports: clk_i, rst_i, tl_i/tl_o bus; re_o, we_o, addr_o, wdata_o, be_o, rdata_i, error_i.
module tlul_reg_adapter
    import top_pkg::*;
    import tlul_pkg::*;
#(
    parameter int RegAw = 8,
    parameter int RegDw = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tl_h2d_t            tl_i,
    output tl_d2h_t            tl_o,
    output logic               re_o,
    output logic               we_o,
    output logic [RegAw-1:0]   addr_o,
    output logic [RegDw-1:0]   wdata_o,
    output logic [RegDw/8-1:0] be_o,
    input  logic [RegDw-1:0]   rdata_i,
    input  logic               error_i
);

    typedef enum logic {
        StIdle,
        StRsp
    } state_e;

    state_e            state_q, state_d;
    tl_d_op_e          op_q, op_d;
    logic              err_q, err_d;
    logic [TL_DW-1:0]  data_q, data_d;
    logic [TL_SZW-1:0] size_q, size_d;
    logic [TL_AIW-1:0] src_q, src_d;

    logic req_err;
    logic a_ready;
    logic accept;
    logic is_get;
    logic is_wr;
    logic rsp_err;

    logic unused_a;
    assign unused_a = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:RegAw]};

    tlul_req_chk u_chk (
        .op_i       (tl_i.a_opcode),
        .addr_lsb_i (tl_i.a_address[1:0]),
        .size_i     (tl_i.a_size),
        .mask_i     (tl_i.a_mask),
        .err_o      (req_err)
    );

    assign is_get  = (tl_i.a_opcode == Get);
    assign is_wr   = (tl_i.a_opcode == PutFullData)
                  || (tl_i.a_opcode == PutPartialData);

    // Ready is forced high in reset; accepts are blocked there instead.
    assign a_ready = rst_i || (state_q == StIdle) || tl_i.d_ready;
    assign accept  = tl_i.a_valid && a_ready && !rst_i;

    assign re_o    = accept && is_get && !req_err;
    assign we_o    = accept && is_wr && !req_err;
    assign addr_o  = {tl_i.a_address[RegAw-1:2], 2'b00};
    assign wdata_o = tl_i.a_data;
    assign be_o    = tl_i.a_mask;

    // Device error only counts when the device was actually strobed.
    assign rsp_err = req_err || (error_i && (re_o || we_o));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        data_d  = data_q;
        size_d  = size_q;
        src_d   = src_q;

        unique case (state_q)
            StIdle: if (accept) state_d = StRsp;
            StRsp: begin
                if (accept) begin
                    state_d = StRsp;
                end else if (tl_i.d_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            op_d   = is_get ? AccessAckData : AccessAck;
            err_d  = rsp_err;
            size_d = tl_i.a_size;
            src_d  = tl_i.a_source;
            if (!is_get) begin
                data_d = '0;
            end else if (rsp_err) begin
                data_d = DataWhenError;
            end else begin
                data_d = rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= AccessAck;
            err_q   <= 1'b0;
            data_q  <= '0;
            size_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            data_q  <= data_d;
            size_q  <= size_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = (state_q == StRsp) && !rst_i;
        tl_o.d_opcode = op_q;
        tl_o.d_param  = '0;
        tl_o.d_size   = size_q;
        tl_o.d_source = src_q;
        tl_o.d_sink   = '0;
        tl_o.d_data   = data_q;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.d_error  = err_q;
        tl_o.a_ready  = a_ready;
    end

endmodule

// File: tb/tb_tlul_reg_adapter.sv
// Scoreboard bench for tlul_reg_adapter: directed requests push expected
// strobes and responses; a negedge monitor pops and compares them.
module tb_tlul_reg_adapter;

    import top_pkg::*;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        re_o, we_o;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic [31:0] rdata_i;
    logic        error_i;

    int vectors = 0;
    int miscompares = 0;

    logic [45:0] sq[$];
    logic [63:0] rq[$];

    always #5 clk = ~clk;

    tlul_reg_adapter #(.RegAw(8), .RegDw(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .re_o    (re_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .be_o    (be_o),
        .rdata_i (rdata_i),
        .error_i (error_i)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rsp_vec();
        return {tl_o.d_opcode, tl_o.d_error, tl_o.d_data, tl_o.d_size,
                tl_o.d_source, tl_o.d_param, tl_o.d_sink, tl_o.d_user};
    endfunction

    // Monitor: compares strobes on accept and responses on handshake.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (tl_i.a_valid && tl_o.a_ready) begin
                if (sq.size() == 0) begin
                    chk("unexpected_accept", 64'd1, 64'd0);
                end else begin
                    chk("strobe", {18'd0, re_o, we_o, addr_o, wdata_o, be_o},
                        {18'd0, sq.pop_front()});
                end
            end else begin
                chk("no_strobe", {62'd0, re_o, we_o}, 64'd0);
            end
            if (tl_o.d_valid && tl_i.d_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    chk("rsp", rsp_vec(), rq.pop_front());
                end
            end
        end
    end

    task automatic drive_req(input tl_a_op_e op, input logic [31:0] addr,
                             input logic [1:0] size, input logic [3:0] mask,
                             input logic [31:0] wd, input logic [7:0] src,
                             input logic [31:0] rd, input logic eio,
                             input logic xre, input logic xwe,
                             input logic xerr, input logic [31:0] xdata,
                             input logic drop);
        tl_d_op_e xop;
        xop = (op == Get) ? AccessAckData : AccessAck;
        sq.push_back({xre, xwe, addr[7:0] & 8'hFC, wd, mask});
        if (!drop) begin
            rq.push_back({xop, xerr, xdata, size, src, 3'd0, 1'b0,
                          TL_D_USER_DEFAULT});
        end
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_size    = size;
        tl_i.a_mask    = mask;
        tl_i.a_data    = wd;
        tl_i.a_source  = src;
        rdata_i        = rd;
        error_i        = eio;
    endtask

    task automatic send(input tl_a_op_e op, input logic [31:0] addr,
                        input logic [1:0] size, input logic [3:0] mask,
                        input logic [31:0] wd, input logic [7:0] src,
                        input logic [31:0] rd, input logic eio,
                        input logic xre, input logic xwe,
                        input logic xerr, input logic [31:0] xdata,
                        input logic drop = 1'b0);
        int n = 0;
        drive_req(op, addr, size, mask, wd, src, rd, eio,
                  xre, xwe, xerr, xdata, drop);
        do begin
            @(negedge clk);
            n++;
        end while (!tl_o.a_ready && n < 20);
        if (n >= 20) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        tl_i.a_valid = 1'b0;
        error_i      = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i   = 1'b1;
        tl_i    = '0;
        rdata_i = '0;
        error_i = 1'b0;
        tl_i.d_ready  = 1'b1;
        tl_i.a_valid  = 1'b1;
        tl_i.a_opcode = Get;
        tl_i.a_size   = 2'd2;
        tl_i.a_mask   = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {62'd0, re_o, we_o}, 64'd0);
        chk("rst_ready_valid", {62'd0, tl_o.a_ready, tl_o.d_valid}, 64'd2);
        @(posedge clk);
        #1;
        tl_i.a_valid = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_state", {tl_o.d_valid, tl_o.d_error, tl_o.d_data,
                          tl_o.d_opcode, tl_o.d_size, tl_o.d_source,
                          tl_o.a_ready},
            {1'b0, 1'b0, 32'd0, AccessAck, 2'd0, 8'd0, 1'b1});
        @(posedge clk);
        #1;

        // op, addr, size, mask, wdata, src, rdata, err_i, re, we, err, data
        send(Get, 32'h10, 2, 4'hF, 0, 8'h01, 32'hCAFE0001, 0,
             1, 0, 0, 32'hCAFE0001);
        send(PutFullData, 32'h04, 2, 4'hF, 32'h12345678, 8'h02, 0, 0,
             0, 1, 0, 32'h0);
        send(Get, 32'h02, 2, 4'hF, 0, 8'h03, 32'h11111111, 0,
             0, 0, 1, 32'hFFFFFFFF);
        send(PutPartialData, 32'h08, 1, 4'h3, 32'hAABBCCDD, 8'h04, 0, 0,
             0, 1, 0, 32'h0);
        send(PutPartialData, 32'h0C, 2, 4'h0, 32'h1, 8'h05, 0, 0,
             0, 0, 1, 32'h0);
        send(PutFullData, 32'h0C, 2, 4'h3, 32'h2, 8'h06, 0, 0,
             0, 0, 1, 32'h0);
        send(Get, 32'h14, 3, 4'hF, 0, 8'h07, 32'h22222222, 0,
             0, 0, 1, 32'hFFFFFFFF);
        send(tl_a_op_e'(3'h2), 32'h18, 2, 4'hF, 32'h3, 8'h08, 0, 0,
             0, 0, 1, 32'h0);
        send(Get, 32'h1C, 2, 4'hF, 0, 8'h09, 32'h00000055, 1,
             1, 0, 1, 32'hFFFFFFFF);
        send(PutFullData, 32'hF0, 2, 4'hF, 32'h9, 8'h0A, 0, 1,
             0, 1, 1, 32'h0);
        drain();

        // Stall: second request waits while first response is held.
        tl_i.d_ready = 1'b0;
        send(Get, 32'h40, 2, 4'hF, 0, 8'h21, 32'hA5A5A5A5, 0,
             1, 0, 0, 32'hA5A5A5A5);
        drive_req(PutFullData, 32'h44, 2, 4'hF, 32'hDEADBEEF, 8'h22, 0, 0,
                  0, 1, 0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", {63'd0, tl_o.a_ready}, 64'd0);
            chk("stall_hold", {tl_o.d_valid, tl_o.d_data, tl_o.d_source},
                {1'b1, 32'hA5A5A5A5, 8'h21});
        end
        @(posedge clk);
        #1;
        tl_i.d_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", {63'd0, tl_o.a_ready}, 64'd1);
        @(posedge clk);
        #1;
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("stall_next_rsp", {63'd0, tl_o.d_valid}, 64'd1);
        drain();

        // Back-to-back Gets: one accept per cycle, d_valid stays high.
        for (int i = 0; i < 4; i++) begin
            drive_req(Get, 32'h20 + 32'(4 * i), 2, 4'hF, 0, 8'h10 + 8'(i),
                      32'hB0000000 + 32'(i), 0, 1, 0, 0,
                      32'hB0000000 + 32'(i), 1'b0);
            @(negedge clk);
            chk("b2b_ready", {63'd0, tl_o.a_ready}, 64'd1);
            if (i > 0) chk("b2b_valid", {63'd0, tl_o.d_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", {63'd0, tl_o.d_valid}, 64'd1);
        drain();

        // Reset while a response is pending drops it.
        tl_i.d_ready = 1'b0;
        send(Get, 32'h30, 2, 4'hF, 0, 8'h33, 32'h77777777, 0,
             1, 0, 0, 32'h77777777, 1'b1);
        @(negedge clk);
        chk("pre_rst_valid", {63'd0, tl_o.d_valid}, 64'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_drop", {62'd0, tl_o.d_valid, tl_o.a_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        tl_i.d_ready = 1'b1;
        @(negedge clk);
        chk("post_rst", {61'd0, tl_o.d_valid, tl_o.a_ready, tl_o.d_error},
            64'd2);
        drain();

        chk("sq_empty", 64'(sq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
